hd63701_irq_arbiter: RTL and testbench

Parametrised interrupt front-end for the HD63701 core.
- Synchronises the external NMI and IRQ inputs and an N-channel IRQ2 source set.
- Latches edge-type requests, masks and prioritises the IRQ2 channels.
- Drives the core's NMI/IRQ/IRQ2/IRQ2V inputs with a stable, locked vector until the sequencer acknowledges it.
- Replaces the single fixed IRQ2/IRQ2V pair with a scalable, per-channel-configurable controller.

---
 rtl/hd63701_irq_arbiter.sv | 175 +++++++++++++++++
 tb/tb_hd63701_irq_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hd63701_irq_arbiter.sv
// Interrupt front-end for the HD63701 core: synchronises NMI/IRQ/IRQ2 sources,
// latches edge requests and presents a locked IRQ2 vector until acknowledged.
module hd63701_irq_arbiter #(
  parameter int unsigned      NCH         = 8,
  parameter int unsigned      VW          = 4,
  parameter logic [NCH-1:0]   EDGE_MASK   = '0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           NMI_IN,
  input  logic           IRQ_IN,
  input  logic [NCH-1:0] SRC,
  input  logic [NCH-1:0] MASK,
  input  logic [NCH-1:0] CLR,
  input  logic           ACK,
  input  logic [1:0]     ACK_KIND,
  output logic           NMI,
  output logic           IRQ,
  output logic           IRQ2,
  output logic [VW-1:0]  IRQ2V,
  output logic [NCH-1:0] PEND
);

  localparam int unsigned IW = NCH + 2;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  // Synchroniser bundle layout: {NMI_IN, IRQ_IN, SRC}
  logic [IW-1:0]  sync_q [SYNC_STAGES];
  logic [IW-1:0]  sync_out;
  logic [NCH:0]   prev_q;
  logic [NCH-1:0] src_sync;
  logic [NCH-1:0] src_rise;
  logic           irq_sync;
  logic           nmi_rise;

  logic           nmi_pend;
  logic           nmi_q;
  logic           irq_lvl;
  logic           irq_q;

  logic [NCH-1:0] pend;
  logic [NCH-1:0] pend_d;
  logic [NCH-1:0] req;
  logic [NCH-1:0] vec_sel;

  arb_state_t     state;
  arb_state_t     state_d;
  logic [VW-1:0]  vec_q;
  logic [VW-1:0]  vec_d;
  logic           irq2_q;
  logic           irq2_d;
  logic [VW-1:0]  win_idx;
  logic           win_found;
  logic           held;

  logic           ack_nmi;
  logic           ack_irq2;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign src_sync = sync_out[NCH-1:0];
  assign irq_sync = sync_out[NCH];
  assign src_rise = src_sync & ~prev_q[NCH-1:0];
  assign nmi_rise = sync_out[NCH+1] & ~prev_q[NCH];

  assign ack_nmi  = ACK && (ACK_KIND == 2'd0);
  assign ack_irq2 = ACK && (ACK_KIND == 2'd2) && (state == LOCKED);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= {NMI_IN, IRQ_IN, SRC};
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= {sync_out[NCH+1], src_sync};
    end
  end

  // One-hot decode of the locked channel, shared by ACK-clear and hold checks
  always_comb begin
    vec_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      vec_sel[i] = (vec_q == VW'(i));
    end
  end

  // Edge channels: a new edge wins over CLR/ACK in the same cycle
  always_comb begin
    pend_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (EDGE_MASK[i]) begin
        pend_d[i] = src_rise[i] | (pend[i] & ~(CLR[i] | (ack_irq2 & vec_sel[i])));
      end else begin
        pend_d[i] = src_sync[i];
      end
    end
  end

  assign req  = pend & ~MASK;
  assign held = |(req & vec_sel);

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (req[i] && !win_found) begin
        win_idx   = VW'(i);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    vec_d   = vec_q;
    irq2_d  = irq2_q;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          vec_d   = win_idx;
          irq2_d  = 1'b1;
        end
      end
      LOCKED: begin
        if (ack_irq2 || !held) begin
          state_d = IDLE;
          irq2_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        irq2_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      vec_q    <= '0;
      irq2_q   <= 1'b0;
      pend     <= '0;
      nmi_pend <= 1'b0;
      nmi_q    <= 1'b0;
      irq_lvl  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state    <= state_d;
      vec_q    <= vec_d;
      irq2_q   <= irq2_d;
      pend     <= pend_d;
      nmi_pend <= nmi_rise | (nmi_pend & ~ack_nmi);
      nmi_q    <= nmi_pend;
      irq_lvl  <= irq_sync;
      irq_q    <= irq_lvl;
    end
  end

  assign NMI   = nmi_q;
  assign IRQ   = irq_q;
  assign IRQ2  = irq2_q;
  assign IRQ2V = vec_q;
  assign PEND  = pend;

endmodule

// File: tb/tb_hd63701_irq_arbiter.sv
// Directed-vector bench for hd63701_irq_arbiter with NCH=8, VW=4,
// EDGE_MASK=8'h0F (ch0-3 edge, ch4-7 level), SYNC_STAGES=2.
module tb_hd63701_irq_arbiter;

  logic       CLK;
  logic       RST;
  logic       NMI_IN;
  logic       IRQ_IN;
  logic [7:0] SRC;
  logic [7:0] MASK;
  logic [7:0] CLR;
  logic       ACK;
  logic [1:0] ACK_KIND;
  logic       NMI;
  logic       IRQ;
  logic       IRQ2;
  logic [3:0] IRQ2V;
  logic [7:0] PEND;

  int n_vec;
  int n_err;

  hd63701_irq_arbiter #(
    .NCH(8),
    .VW(4),
    .EDGE_MASK(8'h0F),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .NMI_IN(NMI_IN),
    .IRQ_IN(IRQ_IN),
    .SRC(SRC),
    .MASK(MASK),
    .CLR(CLR),
    .ACK(ACK),
    .ACK_KIND(ACK_KIND),
    .NMI(NMI),
    .IRQ(IRQ),
    .IRQ2(IRQ2),
    .IRQ2V(IRQ2V),
    .PEND(PEND)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    RST      = 1'b1;
    NMI_IN   = 1'b1;
    IRQ_IN   = 1'b0;
    SRC      = 8'hFF;
    MASK     = 8'h00;
    CLR      = 8'h00;
    ACK      = 1'b0;
    ACK_KIND = 2'd3;

    // Reset with all sources high
    step(3);
    check_eq("rst_nmi",   NMI,   0);
    check_eq("rst_irq",   IRQ,   0);
    check_eq("rst_irq2",  IRQ2,  0);
    check_eq("rst_irq2v", IRQ2V, 0);
    check_eq("rst_pend",  PEND,  0);
    RST = 1'b0;
    step(2);
    check_eq("rel_pend_e2", PEND, 8'h00);
    step(1);
    check_eq("rel_pend_e3", PEND, 8'hFF);
    check_eq("rel_nmi_e3",  NMI,  0);
    step(1);
    check_eq("rel_nmi_e4",   NMI,   1);
    check_eq("rel_irq2_e4",  IRQ2,  1);
    check_eq("rel_irq2v_e4", IRQ2V, 0);

    // Cleanup: ack NMI, clear edge pendings, mask everything
    SRC = 8'h00; NMI_IN = 1'b0; MASK = 8'hFF;
    ACK = 1'b1; ACK_KIND = 2'd0; CLR = 8'h0F;
    step(1);
    ACK = 1'b0; ACK_KIND = 2'd3; CLR = 8'h00;
    check_eq("clean_irq2", IRQ2, 0);
    check_eq("clean_pend_lvl", PEND, 8'hF0);
    step(1);
    check_eq("clean_nmi", NMI, 0);
    step(6);
    MASK = 8'h00;
    step(2);
    check_eq("clean_pend", PEND, 8'h00);
    check_eq("clean_irq2b", IRQ2, 0);

    // IRQ level pass-through, ACK kind 1 does nothing
    IRQ_IN = 1'b1;
    step(3);
    check_eq("irq_e3", IRQ, 0);
    step(1);
    check_eq("irq_e4", IRQ, 1);
    ACK = 1'b1; ACK_KIND = 2'd1;
    step(1);
    ACK = 1'b0; ACK_KIND = 2'd3;
    check_eq("irq_ack", IRQ, 1);
    IRQ_IN = 1'b0;
    step(3);
    check_eq("irq_fall_e3", IRQ, 1);
    step(1);
    check_eq("irq_fall_e4", IRQ, 0);

    // Mask and CLR on edge channel 3
    MASK = 8'h08; SRC = 8'h08;
    step(3);
    check_eq("mask_pend", PEND, 8'h08);
    step(3);
    check_eq("mask_irq2", IRQ2, 0);
    SRC = 8'h00;
    step(3);
    SRC = 8'h08;
    step(2);
    CLR = 8'h08;
    step(1);
    CLR = 8'h00;
    check_eq("clr_race_pend", PEND, 8'h08);
    step(3);
    CLR = 8'h08;
    step(1);
    CLR = 8'h00;
    check_eq("clr_pend", PEND, 8'h00);
    check_eq("clr_irq2", IRQ2, 0);
    MASK = 8'h00; SRC = 8'h00;
    step(4);

    // Latency and priority: ch2 (edge) and ch5 (level)
    SRC = 8'b0010_0100;
    step(3);
    check_eq("lat_irq2_e3", IRQ2, 0);
    check_eq("lat_pend_e3", PEND, 8'h24);
    step(1);
    check_eq("lat_irq2_e4",  IRQ2,  1);
    check_eq("lat_irq2v_e4", IRQ2V, 2);
    ACK = 1'b1; ACK_KIND = 2'd2;
    step(1);
    ACK = 1'b0; ACK_KIND = 2'd3;
    check_eq("ack2_irq2_low", IRQ2, 0);
    check_eq("ack2_pend",     PEND, 8'h20);
    step(1);
    check_eq("regrant_irq2",  IRQ2,  1);
    check_eq("regrant_irq2v", IRQ2V, 5);

    // Lock: ch0 must not preempt ch5
    SRC = 8'b0010_0101;
    step(6);
    check_eq("lock_irq2",  IRQ2,  1);
    check_eq("lock_irq2v", IRQ2V, 5);
    check_eq("lock_pend",  PEND,  8'h21);
    SRC = 8'b0000_0101;
    step(3);
    check_eq("drop_irq2_e3",  IRQ2,  1);
    check_eq("drop_irq2v_e3", IRQ2V, 5);
    step(1);
    check_eq("drop_irq2_e4",  IRQ2,  0);
    check_eq("drop_irq2v_e4", IRQ2V, 5);
    step(1);
    check_eq("drop_irq2_e5",  IRQ2,  1);
    check_eq("drop_irq2v_e5", IRQ2V, 0);
    SRC = 8'h00;
    ACK = 1'b1; ACK_KIND = 2'd2;
    step(1);
    ACK = 1'b0; ACK_KIND = 2'd3;
    check_eq("ack0_irq2", IRQ2, 0);
    step(3);
    check_eq("ack0_pend", PEND, 8'h00);
    check_eq("ack0_idle", IRQ2, 0);

    // NMI: no-op ACKs, then new edge racing ACK kind 0
    NMI_IN = 1'b1;
    step(3);
    check_eq("nmi_e3", NMI, 0);
    step(1);
    check_eq("nmi_e4", NMI, 1);
    ACK = 1'b1; ACK_KIND = 2'd3;
    step(1);
    ACK_KIND = 2'd1;
    step(1);
    ACK_KIND = 2'd2;
    step(1);
    ACK = 1'b0; ACK_KIND = 2'd3;
    step(1);
    check_eq("nmi_noop_ack", NMI, 1);
    check_eq("nmi_noop_irq2", IRQ2, 0);
    NMI_IN = 1'b0;
    step(2);
    NMI_IN = 1'b1;
    step(2);
    ACK = 1'b1; ACK_KIND = 2'd0;
    step(1);
    ACK = 1'b0; ACK_KIND = 2'd3;
    step(1);
    check_eq("nmi_race", NMI, 1);
    ACK = 1'b1; ACK_KIND = 2'd0;
    step(1);
    ACK = 1'b0; ACK_KIND = 2'd3;
    step(1);
    check_eq("nmi_ack2", NMI, 0);
    NMI_IN = 1'b0;
    step(3);

    // Reset while locked on ch1
    SRC = 8'h02;
    step(4);
    check_eq("ml_irq2",  IRQ2,  1);
    check_eq("ml_irq2v", IRQ2V, 1);
    RST = 1'b1; SRC = 8'h00;
    #1;
    check_eq("ml_rst_irq2",  IRQ2,  0);
    check_eq("ml_rst_irq2v", IRQ2V, 0);
    check_eq("ml_rst_pend",  PEND,  0);
    check_eq("ml_rst_nmi",   NMI,   0);
    step(1);
    RST = 1'b0;
    step(5);
    check_eq("ml_post_irq2", IRQ2, 0);
    check_eq("ml_post_pend", PEND, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
